mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
Memory/IO bus handshake unit sitting directly downstream of the multi-cycle CPU controller. It consumes MemRead, MemWrite, CPU_MIO and the address/data buses, and decodes each access to block RAM or to the peripheral window. It inserts region-specific wait states, then returns MIO_ready so the controller can leave IF, MEM_RD and MEM_WD.

Parameters:
RAM_WAIT, 1, wait cycles for RAM accesses; legal values 1..15.
IO_WAIT, 2, wait cycles for IO accesses; legal values 1..15.
RAM_AW, 10, RAM word-address width (1K words).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
MemRead  in  1  read request from the controller
MemWrite  in  1  write request from the controller
CPU_MIO  in  1  qualifies a bus request; request = CPU_MIO & (MemRead | MemWrite)
Addr_bus  in  32  byte address
Cpu_data_out  in  32  write data from the CPU
Ram_data_out  in  32  synchronous-read data from the RAM
Io_data_in  in  32  read data from the peripherals
MIO_ready  out  1  one-cycle access-complete pulse
Cpu_data_in  out  32  registered read data to the CPU
Ram_addr  out  RAM_AW  RAM word address
Ram_we  out  1  RAM write strobe
Ram_data_in  out  32  RAM write data
Io_addr  out  4  peripheral register select, Addr_bus[5:2]
Io_we  out  1  peripheral write strobe
Io_re  out  1  peripheral read enable
Io_data_out  out  32  peripheral write data
Bus_error  out  1  sticky error flag

Behaviour:
- Reset: FSM goes to IDLE. MIO_ready, Ram_we, Io_we, Io_re and Bus_error are 0. Cpu_data_in, Ram_addr and Io_addr are 0.
- Region decode: IO when Addr_bus[31:28] is 4'hE or 4'hF; RAM otherwise. Ram_addr = Addr_bus[RAM_AW+1:2].
- FSM states are IDLE, WAIT and READY.
- IDLE with request:
  - Latch address, write data, direction and region.
  - Load the wait counter with RAM_WAIT or IO_WAIT according to region.
  - Go to WAIT.
  - Ram_addr/Io_addr follow Addr_bus combinationally in IDLE and come from the latched copy afterwards, so a synchronous RAM sees the address in cycle 0.
- WAIT:
  - Counter decrements each cycle. At count 1, capture read data into Cpu_data_in (Ram_data_out or Io_data_in by latched region) and go to READY.
  - Io_re is high during every WAIT cycle of an IO read.
- READY:
  - MIO_ready = 1 for exactly this cycle.
  - For a write, Ram_we or Io_we = 1 for exactly this cycle, with Ram_data_in/Io_data_out = latched write data.
  - Always go to IDLE next.
- Latency: a request first seen in cycle 0 gives MIO_ready in cycle W+1 (W = wait count). Minimum one idle cycle between accesses; a request still high in the cycle after READY starts a new access.
- Request drop during WAIT: abort to IDLE. No strobe, no MIO_ready, and Cpu_data_in is unchanged.
- Error cases, each handled the same way:
  - Cases: MemRead and MemWrite both high, or Addr_bus[1:0] != 0, at request acceptance.
  - Bus_error is set and stays set until reset.
  - The access still completes with normal timing, so the controller never hangs.
  - No write strobe is issued, and Cpu_data_in loads 32'h0.
- Reset mid-access: immediate return to IDLE, all strobes low, no partial write.
- Cpu_data_in holds its value between reads.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, READY=2'b10)
  - IO region nibbles 4'hE/4'hF
  - Error-data constant 32'h0
- One natural sub-module: mio_wait_counter, a 4-bit loadable down-counter with load, enable and a "last" flag.

Test Plan:
- RAM read at 0x0000_0010 with RAM_WAIT=1, RAM word 4 = 0xDEAD_BEEF -> MIO_ready in cycle 2, Cpu_data_in = 0xDEADBEEF, Ram_addr = 4, no strobes.
- IO write 0x0000_00A5 to 0xE000_0004 with IO_WAIT=2 -> Io_we high only in cycle 3 alongside MIO_ready, Io_addr = 1, Io_data_out = 0xA5.
- Back-to-back requests, as in a MEM_WD-then-IF sequence -> write completes, IDLE for one cycle, then the read completes; exactly two MIO_ready pulses.
- Misaligned read at 0x0000_0002 -> Bus_error = 1 and stays high, MIO_ready still arrives in cycle 2, Cpu_data_in = 0.
- Request dropped in the first WAIT cycle of an IO read -> return to IDLE, no MIO_ready, Cpu_data_in unchanged.
- reset asserted during WAIT of a RAM write -> Ram_we never pulses, all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory/IO bus handshake unit:
// FSM encoding, peripheral window decode and the error read value.
package mio_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } mio_state_t;

  // Top address nibbles that select the peripheral window
  localparam logic [3:0] IO_NIB_LO = 4'hE;
  localparam logic [3:0] IO_NIB_HI = 4'hF;

  // Value returned to the CPU for a rejected access
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  function automatic logic is_io_region(input logic [3:0] nib);
    return (nib == IO_NIB_LO) || (nib == IO_NIB_HI);
  endfunction

  // Conflicting direction or a non-word-aligned address
  function automatic logic is_bad_access(input logic       rd,
                                         input logic       wr,
                                         input logic [1:0] lsb);
    return (rd & wr) | (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// Bus bundle between the CPU controller / memories and the handshake unit.
// The master side is everything around the unit (controller, RAM, peripherals);
// the slave side is mio_bus_ctrl itself.
interface mio_bus_if #(
  parameter int RAM_AW = 10
);
  logic              MemRead;
  logic              MemWrite;
  logic              CPU_MIO;
  logic [31:0]       Addr_bus;
  logic [31:0]       Cpu_data_out;
  logic [31:0]       Ram_data_out;
  logic [31:0]       Io_data_in;
  logic              MIO_ready;
  logic [31:0]       Cpu_data_in;
  logic [RAM_AW-1:0] Ram_addr;
  logic              Ram_we;
  logic [31:0]       Ram_data_in;
  logic [3:0]        Io_addr;
  logic              Io_we;
  logic              Io_re;
  logic [31:0]       Io_data_out;
  logic              Bus_error;

  modport master (
    output MemRead, MemWrite, CPU_MIO, Addr_bus, Cpu_data_out,
    output Ram_data_out, Io_data_in,
    input  MIO_ready, Cpu_data_in, Ram_addr, Ram_we, Ram_data_in,
    input  Io_addr, Io_we, Io_re, Io_data_out, Bus_error
  );

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, Addr_bus, Cpu_data_out,
    input  Ram_data_out, Io_data_in,
    output MIO_ready, Cpu_data_in, Ram_addr, Ram_we, Ram_data_in,
    output Io_addr, Io_we, Io_re, Io_data_out, Bus_error
  );
endinterface

// File: rtl/mio_bus_ctrl_wait_counter.sv
// 4-bit loadable down-counter used to time region wait states.
// "last" flags the final wait cycle (count == 1).
module mio_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] cnt_r;

  // Load at access start, count down while waiting, never wrap below zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == 4'd1);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus handshake unit. Accepts a request from the multi-cycle CPU
// controller, decodes RAM vs peripheral window, inserts region wait states and
// answers with a one-cycle MIO_ready pulse. Bad accesses still complete so the
// controller cannot hang, but they raise a sticky Bus_error and never write.
module mio_bus_ctrl #(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 2,
  parameter int RAM_AW   = 10
) (
  input  logic      clk,
  input  logic      reset,
  mio_bus_if.slave  bus
);
  import mio_bus_ctrl_pkg::*;

  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
  localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

  mio_state_t        state_r;
  mio_state_t        state_nxt_s;

  logic              req_s;
  logic              dec_io_s;
  logic              dec_err_s;
  logic              cur_io_s;
  logic              cur_wr_s;
  logic              cur_err_s;
  logic              cnt_load_s;
  logic              cnt_en_s;
  logic              cnt_last_s;
  logic [3:0]        cnt_val_s;
  logic              capture_s;

  logic [RAM_AW-1:0] ram_addr_r;
  logic [3:0]        io_addr_r;
  logic [31:0]       wdata_r;
  logic              wr_r;
  logic              io_r;
  logic              err_r;

  logic              mio_ready_nxt_s;
  logic              ram_we_nxt_s;
  logic              io_we_nxt_s;
  logic              io_re_nxt_s;
  logic              mio_ready_r;
  logic              ram_we_r;
  logic              io_we_r;
  logic              io_re_r;
  logic              bus_error_r;
  logic [31:0]       cpu_data_r;

  assign req_s      = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign dec_io_s   = is_io_region(bus.Addr_bus[31:28]);
  assign dec_err_s  = is_bad_access(bus.MemRead, bus.MemWrite, bus.Addr_bus[1:0]);
  assign cnt_load_s = (state_r == ST_IDLE) & req_s;
  assign cnt_en_s   = (state_r == ST_WAIT);
  assign cnt_val_s  = dec_io_s ? IO_WAIT_C : RAM_WAIT_C;
  // A dropped request in the last wait cycle aborts instead of capturing
  assign capture_s  = (state_r == ST_WAIT) & req_s & cnt_last_s;

  mio_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (cnt_val_s),
    .last     (cnt_last_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_last_s) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_READY: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: next-cycle strobe values, using live decode in IDLE
  always_comb begin
    cur_io_s  = io_r;
    cur_wr_s  = wr_r;
    cur_err_s = err_r;
    if (state_r == ST_IDLE) begin
      cur_io_s  = dec_io_s;
      cur_wr_s  = bus.MemWrite;
      cur_err_s = dec_err_s;
    end else begin
      cur_io_s  = io_r;
      cur_wr_s  = wr_r;
      cur_err_s = err_r;
    end
    mio_ready_nxt_s = (state_nxt_s == ST_READY);
    ram_we_nxt_s    = mio_ready_nxt_s & cur_wr_s & ~cur_io_s & ~cur_err_s;
    io_we_nxt_s     = mio_ready_nxt_s & cur_wr_s &  cur_io_s & ~cur_err_s;
    io_re_nxt_s     = (state_nxt_s == ST_WAIT) & ~cur_wr_s & cur_io_s & ~cur_err_s;
  end

  // Latch the access attributes when a request is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_r <= {RAM_AW{1'b0}};
      io_addr_r  <= 4'h0;
      wdata_r    <= 32'h0000_0000;
      wr_r       <= 1'b0;
      io_r       <= 1'b0;
      err_r      <= 1'b0;
    end else if (cnt_load_s) begin
      ram_addr_r <= bus.Addr_bus[RAM_AW+1:2];
      io_addr_r  <= bus.Addr_bus[5:2];
      wdata_r    <= bus.Cpu_data_out;
      wr_r       <= bus.MemWrite;
      io_r       <= dec_io_s;
      err_r      <= dec_err_s;
    end else begin
      ram_addr_r <= ram_addr_r;
      io_addr_r  <= io_addr_r;
      wdata_r    <= wdata_r;
      wr_r       <= wr_r;
      io_r       <= io_r;
      err_r      <= err_r;
    end
  end

  // Registered handshake and strobe outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mio_ready_r <= 1'b0;
      ram_we_r    <= 1'b0;
      io_we_r     <= 1'b0;
      io_re_r     <= 1'b0;
    end else begin
      mio_ready_r <= mio_ready_nxt_s;
      ram_we_r    <= ram_we_nxt_s;
      io_we_r     <= io_we_nxt_s;
      io_re_r     <= io_re_nxt_s;
    end
  end

  // Read data capture in the final wait cycle; writes leave it untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_data_r <= 32'h0000_0000;
    end else if (capture_s) begin
      if (err_r) begin
        cpu_data_r <= ERR_DATA;
      end else if (!wr_r) begin
        cpu_data_r <= io_r ? bus.Io_data_in : bus.Ram_data_out;
      end else begin
        cpu_data_r <= cpu_data_r;
      end
    end else begin
      cpu_data_r <= cpu_data_r;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_error_r <= 1'b0;
    end else if (cnt_load_s && dec_err_s) begin
      bus_error_r <= 1'b1;
    end else begin
      bus_error_r <= bus_error_r;
    end
  end

  // Address follows the bus in IDLE so a synchronous RAM sees it in cycle 0
  assign bus.Ram_addr    = reset ? {RAM_AW{1'b0}} :
                           ((state_r == ST_IDLE) ? bus.Addr_bus[RAM_AW+1:2] : ram_addr_r);
  assign bus.Io_addr     = reset ? 4'h0 :
                           ((state_r == ST_IDLE) ? bus.Addr_bus[5:2] : io_addr_r);
  assign bus.MIO_ready   = mio_ready_r;
  assign bus.Ram_we      = ram_we_r;
  assign bus.Io_we       = io_we_r;
  assign bus.Io_re       = io_re_r;
  assign bus.Ram_data_in = wdata_r;
  assign bus.Io_data_out = wdata_r;
  assign bus.Cpu_data_in = cpu_data_r;
  assign bus.Bus_error   = bus_error_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl (RAM_WAIT=1, IO_WAIT=2, RAM_AW=10).
// Each issued access pushes its expected completion; a negedge monitor pops
// and compares whenever MIO_ready is seen.
module tb_mio_bus_ctrl;

  logic clk;
  logic reset;

  mio_bus_if #(.RAM_AW(10)) bus ();

  mio_bus_ctrl #(.RAM_WAIT(1), .IO_WAIT(2), .RAM_AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] data;
    logic        ram_we;
    logic        io_we;
    logic        berr;
    logic [9:0]  ram_addr;
    logic [3:0]  io_addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          ready_cnt = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model and peripheral read data
  always @(posedge clk) begin
    if (bus.Ram_we) mem[bus.Ram_addr] <= bus.Ram_data_in;
    ram_q <= mem[bus.Ram_addr];
  end
  assign bus.Ram_data_out = ram_q;
  assign bus.Io_data_in   = 32'hC0DE_0000 | {28'h0, bus.Io_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare each completion against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.MIO_ready === 1'b1) begin
        ready_cnt = ready_cnt + 1;
        if (q.size() == 0) begin
          check("unexpected_ready", {31'h0, bus.MIO_ready}, 32'h0);
        end else begin
          mon_e = q.pop_front();
          check({mon_e.name, "_cycle"},    cyc,             mon_e.cyc);
          check({mon_e.name, "_rdata"},    bus.Cpu_data_in, mon_e.data);
          check({mon_e.name, "_ram_we"},   {31'h0, bus.Ram_we}, {31'h0, mon_e.ram_we});
          check({mon_e.name, "_io_we"},    {31'h0, bus.Io_we},  {31'h0, mon_e.io_we});
          check({mon_e.name, "_bus_err"},  {31'h0, bus.Bus_error}, {31'h0, mon_e.berr});
          check({mon_e.name, "_ram_addr"}, {22'h0, bus.Ram_addr}, {22'h0, mon_e.ram_addr});
          check({mon_e.name, "_io_addr"},  {28'h0, bus.Io_addr},  {28'h0, mon_e.io_addr});
          check({mon_e.name, "_ram_wd"},   bus.Ram_data_in, mon_e.wdata);
          check({mon_e.name, "_io_wd"},    bus.Io_data_out, mon_e.wdata);
        end
      end
      if ((bus.Ram_we | bus.Io_we) && !bus.MIO_ready) begin
        check("stray_strobe", {30'h0, bus.Ram_we, bus.Io_we}, 32'h0);
      end
    end
  end

  // Issue one access, record its expected completion, wait for MIO_ready
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input int w,
                        input logic [31:0] edata, input logic e_rwe, input logic e_iwe,
                        input logic e_berr, input logic [9:0] e_ra, input logic [3:0] e_ia);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    bus.CPU_MIO      = 1'b1;
    bus.MemRead      = rd;
    bus.MemWrite     = wr;
    bus.Addr_bus     = addr;
    bus.Cpu_data_out = wdata;
    e.name = name; e.cyc = cyc + w + 1; e.data = edata; e.ram_we = e_rwe;
    e.io_we = e_iwe; e.berr = e_berr; e.ram_addr = e_ra; e.io_addr = e_ia; e.wdata = wdata;
    q.push_back(e);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.MIO_ready === 1'b1) break;
      k++;
    end
    if (k >= 40) check({name, "_timeout"}, {31'h0, bus.MIO_ready}, 32'h1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.CPU_MIO  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  {31'h0, bus.MIO_ready}, 32'h0);
    check({tag, "_ram_we"}, {31'h0, bus.Ram_we},    32'h0);
    check({tag, "_io_we"},  {31'h0, bus.Io_we},     32'h0);
    check({tag, "_io_re"},  {31'h0, bus.Io_re},     32'h0);
    check({tag, "_berr"},   {31'h0, bus.Bus_error}, 32'h0);
    check({tag, "_rdata"},  bus.Cpu_data_in,        32'h0);
    check({tag, "_raddr"},  {22'h0, bus.Ram_addr},  32'h0);
    check({tag, "_iaddr"},  {28'h0, bus.Io_addr},   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    reset = 1'b0;
    bus.CPU_MIO = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.Addr_bus = 32'h0; bus.Cpu_data_out = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #10 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // RAM read, W=1
    access("ram_rd", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 10'd4, 4'd4);
    idle(2);
    // IO write, W=2: Io_we only with MIO_ready, read data untouched
    access("io_wr", 1'b0, 1'b1, 32'hE000_0004, 32'h0000_00A5, 2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 10'd1, 4'd1);
    idle(2);
    // Back-to-back write then read of the same word
    r0 = ready_cnt;
    access("b2b_wr", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 10'd8, 4'd8);
    access("b2b_rd", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 10'd8, 4'd8);
    idle(2);
    check("b2b_pulses", ready_cnt - r0, 32'd2);
    // IO reads in both window nibbles; 0xD is still RAM
    access("io_rd_e", 1'b1, 1'b0, 32'hE000_0008, 32'h0, 2, 32'hC0DE_0002, 1'b0, 1'b0, 1'b0, 10'd2, 4'd2);
    idle(1);
    access("io_rd_f", 1'b1, 1'b0, 32'hF000_003C, 32'h0, 2, 32'hC0DE_000F, 1'b0, 1'b0, 1'b0, 10'd15, 4'hF);
    idle(1);
    access("ram_rd_d", 1'b1, 1'b0, 32'hD000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 10'd4, 4'd4);
    idle(1);

    // IO read dropped in its first WAIT cycle
    r0 = ready_cnt;
    @(posedge clk); #1;
    bus.CPU_MIO = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Addr_bus = 32'hE000_0000;
    @(posedge clk); #1;
    bus.CPU_MIO = 1'b0; bus.MemRead = 1'b0;
    @(negedge clk);
    check("abort_io_re_wait", {31'h0, bus.Io_re}, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_ready", ready_cnt - r0, 32'd0);
    check("abort_rdata", bus.Cpu_data_in, 32'hDEAD_BEEF);
    check("abort_io_re_low", {31'h0, bus.Io_re}, 32'h0);

    // Error accesses: misaligned, then both directions high
    access("misalign", 1'b1, 1'b0, 32'h0000_0002, 32'h0, 1, 32'h0, 1'b0, 1'b0, 1'b1, 10'd0, 4'd0);
    idle(1);
    access("rd_after_err", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 10'd4, 4'd4);
    idle(1);
    access("both_hi", 1'b1, 1'b1, 32'h0000_0010, 32'hBAD0_BAD0, 1, 32'h0, 1'b0, 1'b0, 1'b1, 10'd4, 4'd4);
    idle(1);
    access("rd_no_write", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 10'd4, 4'd4);
    idle(1);

    // Reset asserted in the WAIT cycle of a RAM write
    @(posedge clk); #1;
    bus.CPU_MIO = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b1;
    bus.Addr_bus = 32'h0000_0010; bus.Cpu_data_out = 32'h0BAD_F00D;
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check_reset_vals("mid_rst");
    bus.CPU_MIO = 1'b0; bus.MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_mem", mem[4], 32'hDEAD_BEEF);
    access("post_rst_rd", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 10'd4, 4'd4);
    idle(2);
    check("queue_drain", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
